// File: rtl/pixel_fb_writer.sv
// Framebuffer write sink: clips incoming (x, y) beats, converts in-bounds points to
// linear addresses, buffers them in a small FIFO and drives a single-port write interface.
module pixel_fb_writer #(
  parameter int FB_WIDTH   = 640,
  parameter int FB_HEIGHT  = 480,
  parameter int ADDR_W     = 19,
  parameter int COLOR_W    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               _clock,
  input  logic               _reset_n,
  input  logic               _start,
  input  logic [COLOR_W-1:0] color,
  input  logic [31:0]        _in0,
  input  logic [31:0]        _in1,
  input  logic               _in_valid,
  output logic               _in_ready,
  input  logic               _in_done,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_data,
  output logic               mem_we,
  input  logic               mem_ready,
  output logic [31:0]        drawn_count,
  output logic [31:0]        clipped_count,
  output logic               _done,
  output logic [1:0]         dbg_state
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  // Valid/ready: a beat (or a write) transfers on a cycle where both valid and ready
  // are high; the source holds its payload steady until then, and ready never depends
  // combinationally on valid.
  logic beat_fire;
  logic push;
  logic pop;

  logic              s1_valid;
  logic              s1_in_bounds;
  logic [ADDR_W-1:0] s1_addr;

  logic              in_bounds;
  logic [ADDR_W-1:0] lin_addr;

  logic [ADDR_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;

  logic [COLOR_W-1:0] color_q;

  // Bounds compare is done on the full signed coordinates; the address only needs
  // the low ADDR_W bits because in-bounds products always fit.
  always_comb begin
    in_bounds = ($signed(_in0) >= 0) && ($signed(_in0) < FB_WIDTH) &&
                ($signed(_in1) >= 0) && ($signed(_in1) < FB_HEIGHT);
    lin_addr  = _in1[ADDR_W-1:0] * ADDR_W'(FB_WIDTH) + _in0[ADDR_W-1:0];
  end

  always_comb begin
    fifo_empty = (fifo_count == CNT_W'(0));
    mem_we     = !fifo_empty;
    mem_addr   = fifo_empty ? '0 : fifo_mem[rd_ptr];
    mem_data   = color_q;
    push       = s1_valid && s1_in_bounds;
    pop        = mem_we && mem_ready;
    // Stage 1 counts against FIFO space so its push can never overflow.
    _in_ready  = (state_q == S_RUN) &&
                 (({1'b0, fifo_count} + {{CNT_W{1'b0}}, s1_valid}) < (CNT_W + 1)'(FIFO_DEPTH));
    beat_fire  = _in_valid && _in_ready;
    _done      = (state_q == S_DONE);
    dbg_state  = state_q;
  end

  always_comb begin
    state_d = state_q;
    if (_start) begin
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_RUN:   if (_in_done) state_d = S_DRAIN;
        S_DRAIN: if (!s1_valid && fifo_empty) state_d = S_DONE;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      s1_valid     <= 1'b0;
      s1_in_bounds <= 1'b0;
      s1_addr      <= '0;
    end else if (_start) begin
      s1_valid     <= 1'b0;
      s1_in_bounds <= 1'b0;
      s1_addr      <= '0;
    end else begin
      s1_valid <= beat_fire;
      if (beat_fire) begin
        s1_in_bounds <= in_bounds;
        s1_addr      <= lin_addr;
      end
    end
  end

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else if (_start) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while the count covers them.
  always_ff @(posedge _clock) begin
    if (push && !_start) begin
      fifo_mem[wr_ptr] <= s1_addr;
    end
  end

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      color_q       <= '0;
      drawn_count   <= '0;
      clipped_count <= '0;
    end else if (_start) begin
      color_q       <= color;
      drawn_count   <= '0;
      clipped_count <= '0;
    end else begin
      if (pop && (drawn_count != 32'hFFFF_FFFF)) begin
        drawn_count <= drawn_count + 32'd1;
      end
      if (s1_valid && !s1_in_bounds && (clipped_count != 32'hFFFF_FFFF)) begin
        clipped_count <= clipped_count + 32'd1;
      end
    end
  end

  fifo_no_overflow: assert property (@(posedge _clock) disable iff (!_reset_n)
    !(push && !pop && (fifo_count == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Directed bench for pixel_fb_writer: a coordinate-level model predicts the write
// stream and counters; one monitor compares every memory write against it.
module tb_pixel_fb_writer;

  localparam int W  = 640;
  localparam int H  = 480;
  localparam int AW = 19;
  localparam int CW = 8;
  localparam int D  = 4;

  // clock / reset / stimulus signals
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] color = '0;
  logic [31:0]   in0 = '0;
  logic [31:0]   in1 = '0;
  logic          in_valid = 1'b0;
  logic          in_done = 1'b0;
  logic          mem_ready = 1'b1;

  logic          in_ready;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] mem_data;
  logic          mem_we;
  logic [31:0]   drawn_count;
  logic [31:0]   clipped_count;
  logic          done;
  logic [1:0]    dbg_state;

  pixel_fb_writer #(
    .FB_WIDTH(W), .FB_HEIGHT(H), .ADDR_W(AW), .COLOR_W(CW), .FIFO_DEPTH(D)
  ) dut (
    ._clock(clk), ._reset_n(rst_n), ._start(start), .color(color),
    ._in0(in0), ._in1(in1), ._in_valid(in_valid), ._in_ready(in_ready),
    ._in_done(in_done), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .mem_ready(mem_ready), .drawn_count(drawn_count), .clipped_count(clipped_count),
    ._done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // scoreboard / model state
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] wlog[$];
  logic [CW-1:0] model_color = '0;
  int            model_drawn = 0;
  int            model_clipped = 0;
  int            acc_total = 0;
  int            cyc = 0;
  int            last_write_cyc = 0;
  int            done_cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  logic          stalled_prev = 1'b0;
  logic [AW-1:0] addr_prev = '0;
  int            mx;
  int            my;
  int            bx[$];
  int            by[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    wlog.delete();
    model_drawn   = 0;
    model_clipped = 0;
    acc_total     = 0;
  endtask

  // monitor / compare process
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      model_clear();
      model_color  = '0;
      stalled_prev = 1'b0;
    end else begin
      if (mem_we) chk("mem_data", 64'(mem_data), 64'(model_color));
      if (stalled_prev && mem_we) chk("stall_addr_stable", 64'(mem_addr), 64'(addr_prev));
      if (mem_we && mem_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0d, expected no write", mem_addr);
        end else begin
          chk("write_addr", 64'(mem_addr), 64'(exp_q.pop_front()));
        end
        wlog.push_back(mem_addr);
        model_drawn++;
        last_write_cyc = cyc;
      end
      stalled_prev = mem_we && !mem_ready;
      addr_prev    = mem_addr;
      if (start) begin
        model_clear();
        model_color = color;
      end else if (in_valid && in_ready) begin
        acc_total++;
        mx = $signed(in0);
        my = $signed(in1);
        if (mx >= 0 && mx < W && my >= 0 && my < H) exp_q.push_back(AW'(my * W + mx));
        else model_clipped++;
      end
    end
  end

  // driver tasks (all return at posedge + 1)
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [CW-1:0] c);
    in_done = 1'b0;
    start   = 1'b1;
    color   = c;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_beats(input int n);
    int idx = 0;
    int budget = 0;
    logic hs;
    while (idx < n && budget < 300) begin
      in0      = bx[idx];
      in1      = by[idx];
      in_valid = 1'b1;
      @(negedge clk);
      hs = in_ready;
      budget++;
      @(posedge clk);
      #1;
      if (hs) idx++;
    end
    in_valid = 1'b0;
    chk("all_beats_accepted", 64'(idx), 64'(n));
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    done_cyc = cyc;
    chk("done_seen", 64'(done), 64'd1);
  endtask

  task automatic check_counts(input string tag, input int drawn_lit, input int clip_lit);
    chk({tag, "_drawn_model"}, 64'(drawn_count), 64'(model_drawn));
    chk({tag, "_clipped_model"}, 64'(clipped_count), 64'(model_clipped));
    chk({tag, "_drawn_lit"}, 64'(drawn_count), 64'(drawn_lit));
    chk({tag, "_clipped_lit"}, 64'(clipped_count), 64'(clip_lit));
    chk({tag, "_nwrites"}, 64'(wlog.size()), 64'(drawn_lit));
    chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    // reset state
    do_reset();
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_data", 64'(mem_data), 64'd0);
    chk("rst_drawn", 64'(drawn_count), 64'd0);
    chk("rst_clipped", 64'(clipped_count), 64'd0);
    chk("rst_state_idle", 64'(dbg_state), 64'd0);
    @(posedge clk);
    #1;

    // basic job
    start_job(8'h5A);
    chk("t1_state_run", 64'(dbg_state), 64'd1);
    bx = '{3, 0, 639};
    by = '{2, 0, 479};
    send_beats(3);
    in_done = 1'b1;
    wait_done(50);
    chk("t1_done_latency", 64'((done_cyc - last_write_cyc) <= 3), 64'd1);
    chk("t1_addr0", 64'(wlog[0]), 64'd1283);
    chk("t1_addr1", 64'(wlog[1]), 64'd0);
    chk("t1_addr2", 64'(wlog[2]), 64'd307199);
    check_counts("t1", 3, 0);
    repeat (3) @(negedge clk);
    chk("t1_done_held", 64'(done), 64'd1);
    @(posedge clk);
    #1;

    // clipping
    start_job(8'hC3);
    bx = '{-1, 640, 0, 5, 10};
    by = '{5, 0, 480, -1, 10};
    send_beats(5);
    in_done = 1'b1;
    wait_done(50);
    chk("t2_addr0", 64'(wlog[0]), 64'd6410);
    check_counts("t2", 1, 4);
    @(posedge clk);
    #1;

    // backpressure
    start_job(8'h11);
    mem_ready = 1'b0;
    bx.delete();
    by.delete();
    for (int i = 0; i < 8; i++) begin
      bx.push_back(i * 7);
      by.push_back(i);
    end
    fork
      send_beats(8);
    join_none
    repeat (12) @(negedge clk);
    chk("t3_accepted_4", 64'(acc_total), 64'd4);
    chk("t3_in_ready_low", 64'(in_ready), 64'd0);
    chk("t3_mem_we_high", 64'(mem_we), 64'd1);
    chk("t3_head_addr", 64'(mem_addr), 64'd0);
    repeat (4) @(negedge clk);
    chk("t3_still_4", 64'(acc_total), 64'd4);
    @(posedge clk);
    #1 mem_ready = 1'b1;
    wait fork;
    in_done = 1'b1;
    wait_done(80);
    for (int i = 0; i < 8; i++) chk("t3_order", 64'(wlog[i]), 64'(647 * i));
    check_counts("t3", 8, 0);
    @(posedge clk);
    #1;

    // rectangle outline from the generator: top, bottom, left, right edges
    start_job(8'h77);
    bx = '{10, 11, 12, 10, 11, 12, 10, 10, 12, 12};
    by = '{20, 20, 20, 21, 21, 21, 20, 21, 20, 21};
    send_beats(10);
    in_done = 1'b1;
    wait_done(50);
    chk("t4_first", 64'(wlog[0]), 64'd12810);
    chk("t4_dup", 64'(wlog[6]), 64'd12810);
    chk("t4_last", 64'(wlog[9]), 64'd13452);
    chk("t4_done_after_write", 64'((done_cyc - last_write_cyc) <= 3), 64'd1);
    check_counts("t4", 10, 0);
    @(posedge clk);
    #1;

    // asynchronous reset mid-job
    start_job(8'h22);
    mem_ready = 1'b0;
    bx = '{1, 2, 3};
    by = '{1, 2, 3};
    send_beats(3);
    repeat (3) @(negedge clk);
    chk("t5_pending", 64'(mem_we), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_mem_we", 64'(mem_we), 64'd0);
    chk("t5_rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("t5_rst_mem_data", 64'(mem_data), 64'd0);
    chk("t5_rst_in_ready", 64'(in_ready), 64'd0);
    chk("t5_rst_state", 64'(dbg_state), 64'd0);
    chk("t5_rst_drawn", 64'(drawn_count), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_no_write", 64'(mem_we), 64'd0);
    end
    chk("t5_state_idle", 64'(dbg_state), 64'd0);
    @(posedge clk);
    #1;

    // start during DRAIN
    start_job(8'h44);
    mem_ready = 1'b0;
    bx = '{4, 5};
    by = '{4, 5};
    send_beats(2);
    in_done = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_state_drain", 64'(dbg_state), 64'd2);
    chk("t6_drain_not_ready", 64'(in_ready), 64'd0);
    chk("t6_drain_not_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    start_job(8'h99);
    @(negedge clk);
    chk("t6_flushed", 64'(mem_we), 64'd0);
    chk("t6_drawn_zero", 64'(drawn_count), 64'd0);
    chk("t6_clipped_zero", 64'(clipped_count), 64'd0);
    chk("t6_done_low", 64'(done), 64'd0);
    chk("t6_in_ready", 64'(in_ready), 64'd1);
    chk("t6_state_run", 64'(dbg_state), 64'd1);
    @(posedge clk);
    #1 mem_ready = 1'b1;
    bx = '{1};
    by = '{0};
    send_beats(1);
    in_done = 1'b1;
    wait_done(50);
    chk("t6_addr", 64'(wlog[0]), 64'd1);
    check_counts("t6", 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected test end");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_fb_writer.md
# pixel_fb_writer

Downstream sink for the coordinate generators (rectangle/line drawers). It accepts a stream of (x, y) pixel coordinates and clips each one against the framebuffer bounds. In-bounds points become linear addresses, which pass through a small FIFO to a single-port framebuffer write interface with backpressure. The block counts drawn and clipped pixels and raises `_done` once the upstream generator has finished and every accepted pixel has been written.

## Interface

Clocking: one clock; reset is asynchronous and active-low (`_reset_n`).

Parameters:
- `FB_WIDTH`, 640: framebuffer width in pixels.
- `FB_HEIGHT`, 480: framebuffer height in pixels.
- `ADDR_W`, 19: framebuffer address width; must satisfy 2^ADDR_W ≥ FB_WIDTH·FB_HEIGHT.
- `COLOR_W`, 8: pixel data width.
- `FIFO_DEPTH`, 4: write-buffer entries; power of two, ≥ 2.

Ports:
- `_clock`  in  1  rising-edge clock.
- `_reset_n`  in  1  asynchronous active-low reset.
- `_start`  in  1  one-cycle pulse; begins a new draw job.
- `color`  in  COLOR_W  pixel value, latched on `_start`.
- `_in0`  in  32  x coordinate, two's-complement.
- `_in1`  in  32  y coordinate, two's-complement.
- `_in_valid`  in  1  coordinate beat valid.
- `_in_ready`  out  1  block can accept a beat.
- `_in_done`  in  1  upstream generator `_done` (level).
- `mem_addr`  out  ADDR_W  framebuffer write address.
- `mem_data`  out  COLOR_W  framebuffer write data.
- `mem_we`  out  1  write request.
- `mem_ready`  in  1  framebuffer accepts the write this cycle.
- `drawn_count`  out  32  pixels written this job.
- `clipped_count`  out  32  pixels discarded this job.
- `_done`  out  1  job complete; held until the next `_start`.

## Operation

- States:
  - IDLE: after reset.
  - RUN
  - DRAIN
  - DONE
- State transitions:
  - `_start` in any state → RUN. It flushes the FIFO and stage-1 register, zeroes both counters, latches `color` and clears `_done`.
  - RUN → DRAIN on the first cycle `_in_done` = 1. A beat handshaken in that same cycle is still processed.
  - DRAIN → DONE when stage 1 and the FIFO are both empty and no write is pending. On entry to DONE, `_done` ← 1.
- Input handshake:
  - A beat transfers when `_in_valid && _in_ready`.
  - `_in_ready` = (state == RUN) && (fifo_count + stage1_valid < FIFO_DEPTH).
  - `_in_ready` is 0 in IDLE, DRAIN and DONE.
- Stage 1 (registered): a point is in bounds when 0 ≤ x < FB_WIDTH and 0 ≤ y < FB_HEIGHT, compared as signed 32-bit values.
  - In bounds: addr = y·FB_WIDTH + x, truncated to ADDR_W.
  - Out of bounds: `clipped_count` += 1 and nothing is pushed.
- FIFO: stage 1 pushes in-bounds entries. The FIFO pops when `mem_we && mem_ready`; push and pop in the same cycle are both allowed.
- Memory port:
  - `mem_we` = FIFO non-empty.
  - `mem_addr` = FIFO head; `mem_data` = latched color.
  - `mem_addr` and `mem_data` stay stable while `mem_we && !mem_ready`.
  - Each completed write increments `drawn_count`.
- Counters saturate at 2^32−1.
- Duplicate coordinates are written again, not merged.

## Timing

- Reset values:
  - `_in_ready`, `mem_we`, `_done`: 0.
  - `mem_addr`, `mem_data`, `drawn_count`, `clipped_count`: 0.
  - State: IDLE; FIFO empty.
- Latency:
  - A beat accepted at cycle N is in stage 1 at N+1 and drives `mem_we` at N+2 at the earliest (FIFO empty, RUN).
  - A clipped beat increments `clipped_count`, visible at N+2.
- Throughput: one pixel per cycle while `mem_ready` = 1.
- Backpressure: with `mem_ready` held at 0, at most FIFO_DEPTH beats are accepted. `_in_ready` then stays 0 until a write completes.
- `_done` rises at the earliest one cycle after the last write completes. It stays high until `_start` or reset.
- `_reset_n` asserted mid-job: all state clears immediately and asynchronously; pending writes are dropped.
- `_start` mid-job: same as reset, except `color` is latched and the state goes to RUN.

## Test plan

- Reset, then `_start` with color=0x5A; beats (3,2), (0,0), (639,479); `mem_ready`=1. Expect:
  - writes to addresses 1283, 0, 307199, each with data 0x5A;
  - `drawn_count`=3 and `clipped_count`=0;
  - `_in_done` raised after the last beat gives `_done`=1 within 3 cycles of the last write.
- Clipping: beats (−1,5), (640,0), (0,480), (5,−1), (10,10). Expect only address 6410 written; `clipped_count`=4, `drawn_count`=1.
- Backpressure: `mem_ready`=0 while 8 beats are offered. Expect:
  - exactly 4 accepted and `_in_ready` low thereafter;
  - `mem_addr` stable while stalled;
  - releasing `mem_ready` writes all 8 in order.
- Drive the `draw_rectangle` generator (s_x=10, s_y=20, width=3, height=2) as upstream. Expect 10 writes in generator order and `_done` after the final write.
- Reset mid-job with 3 FIFO entries: async `_reset_n` low for 1 cycle. Expect outputs cleared immediately, no further `mem_we`, state IDLE.
- `_start` during DRAIN. Expect FIFO flushed, counters zeroed, `_done`=0, `_in_ready`=1 on the next cycle.
